// File: rtl/mem_domain_seq.sv
// Per-domain bring-up sequencer: staggered channel reset release, calibration supervision,
// NoC gating and stability-filtered chip-ID sync. Define MEM_DOMAIN_SEQ_RETRY_EN to enable calibration retries.
module mem_domain_seq #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CHIPID_W    = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RST_HOLD    = 16,
    parameter int unsigned STAGGER     = 8,
    parameter int unsigned CAL_TIMEOUT = 1024,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic                  clk_i,
    input  logic                  sys_rst,
    input  logic [CHIPID_W-1:0]   home_chipid_i,
    input  logic [NUM_CH-1:0]     calib_done_i,
    input  logic [NUM_CH-1:0]     restart_i,
    output logic [CHIPID_W-1:0]   home_chipid_o,
    output logic [NUM_CH-1:0]     ch_rst_n_o,
    output logic [NUM_CH-1:0]     noc_en_o,
    output logic                  all_ready_o,
    output logic                  err_o,
    output logic [4*NUM_CH-1:0]   status_o
);
    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        CAL_WAIT = 2'd1,
        READY    = 2'd2,
        ERROR    = 2'd3
    } state_t;

`ifdef MEM_DOMAIN_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam int unsigned HOLD_MAX = RST_HOLD + (NUM_CH - 1) * STAGGER;
    localparam int unsigned CNT_MAX  = (HOLD_MAX > CAL_TIMEOUT - 1) ? HOLD_MAX : CAL_TIMEOUT - 1;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    logic [SYNC_STAGES-1:0][NUM_CH-1:0]   cal_ff;
    logic [SYNC_STAGES-1:0][CHIPID_W-1:0] id_ff;
    logic [NUM_CH-1:0]                    cal_sync;
    logic [NUM_CH-1:0]                    ready_v;
    logic [NUM_CH-1:0]                    err_v;

    assign cal_sync = cal_ff[SYNC_STAGES-1];

    // Chip ID is taken only when the last two synchroniser stages agree, so a moving bus never leaks through.
    always_ff @(posedge clk_i or posedge sys_rst) begin
        if (sys_rst) begin
            cal_ff        <= '0;
            id_ff         <= '0;
            home_chipid_o <= '0;
        end else begin
            cal_ff <= {cal_ff[SYNC_STAGES-2:0], calib_done_i};
            id_ff  <= {id_ff[SYNC_STAGES-2:0], home_chipid_i};
            if (id_ff[SYNC_STAGES-1] == id_ff[SYNC_STAGES-2])
                home_chipid_o <= id_ff[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk_i or posedge sys_rst) begin
        if (sys_rst) begin
            all_ready_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            all_ready_o <= &ready_v;
            err_o       <= |err_v;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            localparam int unsigned FIRST_HOLD = RST_HOLD + i * STAGGER;

            state_t           st;
            logic [CNT_W-1:0] cnt;
            logic [1:0]       retry;
            logic             first;
            logic             rst_n;
            logic             noc;
            logic             hold_done;
            logic             timeout;

            // The post-reset hold counts from the first edge after release, re-entries count from entry.
            assign hold_done = first ? (cnt == CNT_W'(FIRST_HOLD)) : (cnt == CNT_W'(RST_HOLD - 1));
            assign timeout   = (cnt == CNT_W'(CAL_TIMEOUT - 1));

            always_ff @(posedge clk_i or posedge sys_rst) begin
                if (sys_rst) begin
                    st    <= HOLD;
                    cnt   <= '0;
                    retry <= '0;
                    first <= 1'b1;
                    rst_n <= 1'b0;
                    noc   <= 1'b0;
                end else begin
                    case (st)
                        HOLD: begin
                            if (hold_done) begin
                                st    <= CAL_WAIT;
                                cnt   <= '0;
                                first <= 1'b0;
                                rst_n <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        CAL_WAIT: begin
                            if (cal_sync[i]) begin
                                st  <= READY;
                                cnt <= '0;
                                noc <= 1'b1;
                            end else if (timeout) begin
                                cnt <= '0;
                                if (RETRY_EN && (retry < 2'(MAX_RETRY))) begin
                                    st    <= HOLD;
                                    rst_n <= 1'b0;
                                    retry <= retry + 2'd1;
                                end else begin
                                    st <= ERROR;
                                end
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        READY: begin
                            if (!cal_sync[i]) begin
                                st  <= ERROR;
                                cnt <= '0;
                                noc <= 1'b0;
                            end
                        end
                        ERROR: begin
                            if (restart_i[i]) begin
                                st    <= HOLD;
                                cnt   <= '0;
                                retry <= '0;
                                rst_n <= 1'b0;
                            end
                        end
                    endcase
                end
            end

            assign ch_rst_n_o[i]      = rst_n;
            assign noc_en_o[i]        = noc;
            assign ready_v[i]         = (st == READY);
            assign err_v[i]           = (st == ERROR);
            assign status_o[4*i +: 4] = {retry, st};
        end
    endgenerate
endmodule

// File: tb/tb_mem_domain_seq.sv
// Scoreboard bench for mem_domain_seq: a deadline-based reference model predicts every cycle's outputs.
module tb_mem_domain_seq;
    localparam int unsigned NUM_CH      = 2;
    localparam int unsigned CHIPID_W    = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned RST_HOLD    = 16;
    localparam int unsigned STAGGER     = 8;
    localparam int unsigned CAL_TIMEOUT = 32;
    localparam int unsigned MAX_RETRY   = 2;
`ifdef MEM_DOMAIN_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                sys_rst = 1'b1;
    logic [CHIPID_W-1:0] chip_in = 8'h5A;
    logic [NUM_CH-1:0]   cal_in = '0;
    logic [NUM_CH-1:0]   rs_in = '0;
    logic [CHIPID_W-1:0] home_chipid_o;
    logic [NUM_CH-1:0]   ch_rst_n_o;
    logic [NUM_CH-1:0]   noc_en_o;
    logic                all_ready_o;
    logic                err_o;
    logic [4*NUM_CH-1:0] status_o;

    mem_domain_seq #(
        .NUM_CH(NUM_CH), .CHIPID_W(CHIPID_W), .SYNC_STAGES(SYNC_STAGES), .RST_HOLD(RST_HOLD),
        .STAGGER(STAGGER), .CAL_TIMEOUT(CAL_TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk_i(clk), .sys_rst(sys_rst), .home_chipid_i(chip_in), .calib_done_i(cal_in),
        .restart_i(rs_in), .home_chipid_o(home_chipid_o), .ch_rst_n_o(ch_rst_n_o),
        .noc_en_o(noc_en_o), .all_ready_o(all_ready_o), .err_o(err_o), .status_o(status_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CHIPID_W-1:0] id;
        logic [NUM_CH-1:0]   rst_n;
        logic [NUM_CH-1:0]   noc;
        logic                ar;
        logic                er;
        logic [4*NUM_CH-1:0] status;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference model: channel states 0 HOLD, 1 CAL_WAIT, 2 READY, 3 ERROR; deadlines are absolute edge numbers.
    int                  m_state[NUM_CH];
    int                  m_release[NUM_CH];
    int                  m_timeout[NUM_CH];
    int                  m_retry[NUM_CH];
    logic [CHIPID_W-1:0] m_id;
    logic                m_ar, m_er;
    int                  edge_n;
    logic [NUM_CH-1:0]   cal_h[$];
    logic [CHIPID_W-1:0] id_h[$];

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, got, exp);
    endfunction

    function automatic void model_reset();
        edge_n = 0;
        cal_h.delete();
        id_h.delete();
        m_id = '0;
        m_ar = 1'b0;
        m_er = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_state[ch]   = 0;
            m_release[ch] = RST_HOLD + ch * STAGGER;
            m_timeout[ch] = 0;
            m_retry[ch]   = 0;
        end
    endfunction

    function automatic logic [NUM_CH-1:0] cal_at(input int k);
        return (k < 0) ? '0 : cal_h[k];
    endfunction

    function automatic logic [CHIPID_W-1:0] id_at(input int k);
        return (k < 0) ? '0 : id_h[k];
    endfunction

    function automatic void model_step();
        int t;
        logic [NUM_CH-1:0] seen;
        logic all_r, any_e;
        cal_h.push_back(cal_in);
        id_h.push_back(chip_in);
        t = edge_n;
        seen = cal_at(t - SYNC_STAGES);
        all_r = 1'b1;
        any_e = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            all_r &= (m_state[ch] == 2);
            any_e |= (m_state[ch] == 3);
        end
        m_ar = all_r;
        m_er = any_e;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            case (m_state[ch])
                0: if (t == m_release[ch]) begin
                       m_state[ch] = 1;
                       m_timeout[ch] = t + CAL_TIMEOUT;
                   end
                1: if (seen[ch]) m_state[ch] = 2;
                   else if (t == m_timeout[ch]) begin
                       if (RETRY_EN && m_retry[ch] < MAX_RETRY) begin
                           m_retry[ch]++;
                           m_state[ch] = 0;
                           m_release[ch] = t + RST_HOLD;
                       end else m_state[ch] = 3;
                   end
                2: if (!seen[ch]) m_state[ch] = 3;
                default: if (rs_in[ch]) begin
                       m_state[ch] = 0;
                       m_retry[ch] = 0;
                       m_release[ch] = t + RST_HOLD;
                   end
            endcase
        end
        if (id_at(t - SYNC_STAGES) == id_at(t - SYNC_STAGES + 1)) m_id = id_at(t - SYNC_STAGES);
        edge_n++;
    endfunction

    task automatic tick(input logic [NUM_CH-1:0] cal, input logic [NUM_CH-1:0] rs, input logic [CHIPID_W-1:0] id);
        exp_t e;
        @(posedge clk);
        model_step();
        e.id = m_id;
        e.ar = m_ar;
        e.er = m_er;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            e.rst_n[ch] = (m_state[ch] != 0);
            e.noc[ch] = (m_state[ch] == 2);
            e.status[4*ch +: 4] = {2'(m_retry[ch]), 2'(m_state[ch])};
        end
        exp_q.push_back(e);
        #1;
        cal_in = cal;
        rs_in = rs;
        chip_in = id;
    endtask

    task automatic apply_reset(input int hold_edges);
        @(negedge clk);
        #1 sys_rst = 1'b1;
        #1;
        check("rst_chipid", 32'(home_chipid_o), 0);
        check("rst_ch_rst_n", 32'(ch_rst_n_o), 0);
        check("rst_noc_en", 32'(noc_en_o), 0);
        check("rst_all_ready", 32'(all_ready_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_status", 32'(status_o), 0);
        cal_in = '0;
        rs_in = '0;
        repeat (hold_edges) @(posedge clk);
        @(negedge clk);
        sys_rst = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("chipid", 32'(home_chipid_o), 32'(e.id));
            check("ch_rst_n", 32'(ch_rst_n_o), 32'(e.rst_n));
            check("noc_en", 32'(noc_en_o), 32'(e.noc));
            check("all_ready", 32'(all_ready_o), 32'(e.ar));
            check("err", 32'(err_o), 32'(e.er));
            check("status", 32'(status_o), 32'(e.status));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded its time limit");
        n_checks++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NUM_CH-1:0]   cal_s;
        logic [CHIPID_W-1:0] id_s;
        logic [NUM_CH-1:0]   rs;
        int c0, c1, k;

        id_s = 8'h5A;
        cal_s = '0;
        apply_reset(2);

        // Bring-up: ch0 calibrates at cycle 40, ch1 at a random cycle inside its window.
        c1 = $urandom_range(25, 50);
        for (int c = 0; c < 80; c++) tick({1'(c >= c1), 1'(c >= 40)}, '0, id_s);
        cal_s = 2'b11;
        check("bringup_all_ready", 32'(all_ready_o), 1);
        check("bringup_status", 32'(status_o), 32'h22);

        // Calibration loss on ch0, restart, recalibration.
        cal_s[0] = 1'b0;
        repeat ($urandom_range(6, 10)) tick(cal_s, '0, id_s);
        check("loss_noc_en", 32'(noc_en_o), 32'b10);
        tick(cal_s, 2'b01, id_s);
        repeat ($urandom_range(5, 30)) tick(cal_s, '0, id_s);
        cal_s[0] = 1'b1;
        repeat (40) tick(cal_s, '0, id_s);

        // ch1 never recalibrates after restart: timeout path to ERROR.
        cal_s[1] = 1'b0;
        repeat (8) tick(cal_s, '0, id_s);
        tick(cal_s, 2'b10, id_s);
        repeat (200) tick(cal_s, '0, id_s);
        check("timeout_status_ch1", 32'(status_o[7:4]), RETRY_EN ? 32'hB : 32'h3);
        check("timeout_status_ch0", 32'(status_o[3:0]), 32'h2);
        check("timeout_err", 32'(err_o), 1);
        check("timeout_noc_en", 32'(noc_en_o), 32'b01);

        // Chip ID toggling never passes through; a stable value lands after SYNC_STAGES+1 cycles.
        for (int j = 0; j < 12; j++) begin
            tick(cal_s, '0, (j % 2 == 1) ? 8'h34 : 8'h12);
            check("chipid_toggle_hold", 32'(home_chipid_o), 32'h5A);
        end
        id_s = 8'h56;
        tick(cal_s, '0, id_s);
        repeat (2) tick(cal_s, '0, id_s);
        check("chipid_not_yet", 32'(home_chipid_o), 32'h5A);
        tick(cal_s, '0, id_s);
        check("chipid_settled", 32'(home_chipid_o), 32'h56);

        // Reset while ch0 is READY, then a fresh staggered bring-up.
        apply_reset(1);
        cal_s = '0;
        c0 = $urandom_range(20, 45);
        c1 = $urandom_range(20, 45);
        for (int c = 0; c < 80; c++) tick({1'(c >= c1), 1'(c >= c0)}, '0, id_s);
        cal_s = 2'b11;
        check("rerun_all_ready", 32'(all_ready_o), 1);

        // Random soak with one more asynchronous reset in the middle.
        for (int n = 0; n < 2500; n++) begin
            if (n == 1200) begin
                apply_reset(3);
                cal_s = '0;
            end
            for (int ch = 0; ch < NUM_CH; ch++)
                if ($urandom_range(0, 39) == 0) cal_s[ch] = ~cal_s[ch];
            rs = '0;
            for (int ch = 0; ch < NUM_CH; ch++)
                if ($urandom_range(0, 24) == 0) rs[ch] = 1'b1;
            k = $urandom_range(0, 15);
            if (k == 0) id_s = 8'($urandom);
            tick(cal_s, rs, id_s);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
